// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: two-input packet mux with a round-robin grant FSM.
//   A requester owns the mux from its grant until the beat carrying its last
//   flag. It may drop req or see out_ready low while it holds the grant; the
//   grant stays put. On the final beat, ownership passes straight to the other
//   requester if it is requesting, so no idle cycle is inserted.
//
// Optional feature: define MUX_ARB_TIMEOUT_EN to force release after MAX_HOLD
//   consecutive granted cycles without a beat. In that cycle, timeout pulses.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   din_0/din_1         requester data (DATA_W)
//   req_0/req_1         requester valid/request
//   last_0/last_1       final beat of the requester's packet
//   out_ready           downstream accepts the current beat
//   gnt_0/gnt_1         ownership (one-hot or zero)
//   sel                 registered mux select (1 = din_1)
//   mux_out             combinational sel ? din_1 : din_0
//   out_valid           owner is presenting a beat
//   timeout             one-cycle pulse on forced release
module mux_rr_arbiter #(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din_0,
   input  logic [DATA_W-1:0] din_1,
   input  logic              req_0,
   input  logic              req_1,
   input  logic              last_0,
   input  logic              last_1,
   input  logic              out_ready,
   output logic              gnt_0,
   output logic              gnt_1,
   output logic              sel,
   output logic [DATA_W-1:0] mux_out,
   output logic              out_valid,
   output logic              timeout
);

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT_0 = 2'd1, GRANT_1 = 2'd2} state_t;

   state_t state, state_nxt;
   logic   last_win, last_win_nxt;   // 1 after reset, so requester 0 goes first
   logic   sel_nxt;
   logic   beat, own_last, release_grant, force_rel;

   assign beat          = out_valid & out_ready;
   assign own_last      = (state == GRANT_1) ? last_1 : last_0;
   assign release_grant = (beat & own_last) | force_rel;

`ifdef MUX_ARB_TIMEOUT_EN
   localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   logic [CNT_W-1:0] stall_cnt;

   // Fires during the MAX_HOLD-th consecutive stalled granted cycle.
   assign force_rel = (state != IDLE) & ~beat & (stall_cnt == CNT_W'(MAX_HOLD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (state == IDLE || beat || state_nxt != state)
         stall_cnt <= '0;
      else
         stall_cnt <= stall_cnt + 1'b1;
   end
`else
   assign force_rel = 1'b0;
`endif

   assign timeout = force_rel;

   // State register. sel is kept as its own flop so it is a registered output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last_win <= 1'b1;
         sel      <= 1'b0;
      end else begin
         state    <= state_nxt;
         last_win <= last_win_nxt;
         sel      <= sel_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_0 && req_1) state_nxt = last_win ? GRANT_0 : GRANT_1;
            else if (req_0)     state_nxt = GRANT_0;
            else if (req_1)     state_nxt = GRANT_1;
         end
         GRANT_0: if (release_grant) state_nxt = req_1 ? GRANT_1 : IDLE;
         GRANT_1: if (release_grant) state_nxt = req_0 ? GRANT_0 : IDLE;
         default: state_nxt = IDLE;
      endcase

      last_win_nxt = last_win;
      if (state_nxt == GRANT_0 && state != GRANT_0) last_win_nxt = 1'b0;
      if (state_nxt == GRANT_1 && state != GRANT_1) last_win_nxt = 1'b1;
      sel_nxt = (state_nxt == GRANT_1);
   end

   // Output logic.
   always_comb begin
      gnt_0     = (state == GRANT_0);
      gnt_1     = (state == GRANT_1);
      out_valid = (gnt_0 & req_0) | (gnt_1 & req_1);
      mux_out   = sel ? din_1 : din_0;
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
   localparam int DW = 8;
   localparam int MH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] din_0, din_1;
   logic          req_0, req_1, last_0, last_1, out_ready;
   logic          gnt_0, gnt_1, sel, out_valid, timeout;
   logic [DW-1:0] mux_out;

   mux_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n), .din_0(din_0), .din_1(din_1),
      .req_0(req_0), .req_1(req_1), .last_0(last_0), .last_1(last_1),
      .out_ready(out_ready), .gnt_0(gnt_0), .gnt_1(gnt_1), .sel(sel),
      .mux_out(mux_out), .out_valid(out_valid), .timeout(timeout));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: who owns the mux (-1 = nobody), who won last, stall run.
   int owner, last_win, stalls;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_valid();
      return (owner == 0 && req_0) || (owner == 1 && req_1);
   endfunction

   function automatic bit m_timeout();
`ifdef MUX_ARB_TIMEOUT_EN
      return owner != -1 && !(m_valid() && out_ready) && stalls == MH - 1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      owner = -1; last_win = 1; stalls = 0;
   endtask

   task automatic model_edge();
      bit beat, own_last, rel;
      int other;
      beat = m_valid() && out_ready;
      if (owner == -1) begin
         if (req_0 && req_1) owner = (last_win == 0) ? 1 : 0;
         else if (req_0)     owner = 0;
         else if (req_1)     owner = 1;
         if (owner != -1) last_win = owner;
         stalls = 0;
      end else begin
         own_last = (owner == 0) ? last_0 : last_1;
         rel = (beat && own_last) || m_timeout();
         stalls = beat ? 0 : stalls + 1;
         if (rel) begin
            other = 1 - owner;
            if ((other == 0) ? req_0 : req_1) begin
               owner = other; last_win = other;
            end else
               owner = -1;
            stalls = 0;
         end
      end
   endtask

   task automatic check_outs(input string tag);
      chk({tag, ".gnt_0"},     gnt_0,     owner == 0);
      chk({tag, ".gnt_1"},     gnt_1,     owner == 1);
      chk({tag, ".sel"},       sel,       owner == 1);
      chk({tag, ".out_valid"}, out_valid, m_valid());
      chk({tag, ".mux_out"},   mux_out,   (owner == 1) ? din_1 : din_0);
      chk({tag, ".timeout"},   timeout,   m_timeout());
      chk({tag, ".onehot"},    gnt_0 & gnt_1, 1'b0);
   endtask

   // Drive one cycle of inputs just after a rising edge, check, then clock.
   task automatic cycle(input string tag, input logic r0, r1, l0, l1, rdy,
                        input logic [DW-1:0] d0, d1);
      req_0 = r0; req_1 = r1; last_0 = l0; last_1 = l1; out_ready = rdy;
      din_0 = d0; din_1 = d1;
      #2;
      check_outs(tag);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Asynchronous reset asserted mid-cycle, released just after an edge.
   task automatic do_reset();
      #1 rst_n = 1'b0;
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   int beats;

   initial begin
      rst_n = 1'b0; req_0 = 1; req_1 = 1; last_0 = 0; last_1 = 0; out_ready = 1;
      din_0 = 8'h3C; din_1 = 8'hC3;
      model_reset();
      #12;
      chk("rst.gnt_0", gnt_0, 0);
      chk("rst.gnt_1", gnt_1, 0);
      chk("rst.sel", sel, 0);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.timeout", timeout, 0);
      chk("rst.mux_out", mux_out, 8'h3C);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // single requester: grant next cycle, beat, back to idle
      cycle("single0", 1, 0, 1, 0, 1, 8'hA5, 8'h00);
      chk("single.gnt_0", gnt_0, 1);
      cycle("single1", 1, 0, 1, 0, 1, 8'hA5, 8'h00);
      chk("single.idle", gnt_0 | gnt_1, 0);
      cycle("single2", 0, 0, 0, 0, 1, 8'h11, 8'h22);

      // both requesting, single-beat packets: strict alternation, no bubble
      do_reset();
      cycle("alt_idle", 1, 1, 1, 1, 1, 8'h01, 8'h02);
      for (int i = 0; i < 6; i++) begin
         chk("alt.sel", sel, i % 2);
         cycle("alt", 1, 1, 1, 1, 1, DW'(i), DW'(i + 8'h80));
      end

      // 3-beat packet on requester 1 while requester 0 waits
      do_reset();
      cycle("pkt_g", 0, 1, 0, 0, 1, 8'h00, 8'h10);
      cycle("pkt_b0", 1, 1, 0, 0, 1, 8'h00, 8'h11);
      chk("pkt.hold0", gnt_1, 1);
      cycle("pkt_b1", 1, 1, 0, 0, 1, 8'h00, 8'h12);
      chk("pkt.hold1", gnt_1, 1);
      cycle("pkt_b2", 1, 1, 1, 1, 1, 8'h00, 8'h13);
      chk("pkt.handoff", gnt_0, 1);

      // backpressure mid-packet
      do_reset();
      beats = 0;
      cycle("bp_g", 1, 0, 0, 0, 1, 8'h20, 8'h00);
      cycle("bp_b0", 1, 0, 0, 0, 1, 8'h21, 8'h00);
      beats++;
      for (int i = 0; i < 5; i++) begin
         cycle("bp_stall", 1, 0, 1, 0, 0, 8'h22, 8'h00);
         if (!(MH <= 5 && i == MH - 1)) chk("bp.gnt", gnt_0, owner == 0);
         if (out_valid && out_ready) beats++;
      end
      chk("bp.beats", beats, 1);

      // asynchronous reset during GRANT_1
      do_reset();
      cycle("ar_g", 0, 1, 0, 0, 1, 8'h30, 8'h31);
      cycle("ar_b", 1, 1, 0, 0, 1, 8'h30, 8'h32);
      #2 rst_n = 1'b0;
      #1;
      chk("ar.gnt_1", gnt_1, 0);
      chk("ar.sel", sel, 0);
      chk("ar.mux_out", mux_out, din_0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle("ar_rel", 1, 1, 1, 1, 1, 8'h33, 8'h34);
      chk("ar.win0", gnt_0, 1);

      // stalled owner: forced release with the option, held forever without
      do_reset();
      cycle("to_g", 0, 1, 0, 0, 0, 8'h40, 8'h41);
      for (int i = 0; i < MH; i++) cycle("to_stall", 1, 1, 0, 0, 0, 8'h40, 8'h41);
`ifdef MUX_ARB_TIMEOUT_EN
      chk("to.xfer", gnt_0, 1);
`else
      for (int i = 0; i < 10; i++) cycle("to_stall", 1, 1, 0, 0, 0, 8'h40, 8'h41);
      chk("to.persist", gnt_1, 1);
`endif

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         cycle("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 3) != 0), DW'($urandom), DW'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
